// File: rtl/tile_map_fetch_pkg.sv
// Shared tile-map and VGA timing definitions, common to the tile fetch stage and the sprite renderer.
package tile_map_fetch_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FPORCH = 16;
  localparam int unsigned H_PULSE  = 96;
  localparam int unsigned H_BPORCH = 48;
  localparam int unsigned H_MAX    = 800;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FPORCH = 10;
  localparam int unsigned V_PULSE  = 2;
  localparam int unsigned V_BPORCH = 33;
  localparam int unsigned V_MAX    = 525;

  localparam int unsigned TILES_X    = 40;
  localparam int unsigned TILES_Y    = 30;
  localparam int unsigned NUM_TILES  = TILES_X * TILES_Y;
  localparam int unsigned IDX_W      = 6;
  localparam int unsigned TILE_AW    = 11;
  localparam int unsigned TX_W       = 6;
  localparam int unsigned TY_W       = 5;
  localparam int unsigned COORD_W    = 10;
  localparam int unsigned SROW_W     = 3;
  localparam int unsigned TILE_SHIFT = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } map_state_e;

  typedef struct packed {
    logic [TY_W-1:0]  y;
    logic [TX_W-1:0]  x;
    logic [IDX_W-1:0] data;
  } tile_wr_t;

  // Row-major tile address y*40 + x, built from shifts (y*32 + y*8 + x).
  function automatic logic [TILE_AW-1:0] tile_addr(input logic [TY_W-1:0] ty,
                                                   input logic [TX_W-1:0] tx);
    return TILE_AW'({ty, 5'b0}) + TILE_AW'({ty, 3'b0}) + TILE_AW'(tx);
  endfunction

endpackage

// File: rtl/tile_map_ram.sv
// 1200 x IDX_W simple dual-port map RAM; synchronous read returns old data on a same-address write.
module tile_map_ram
  import tile_map_fetch_pkg::*;
(
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [TILE_AW-1:0] waddr_i,
  input  logic [IDX_W-1:0]   wdata_i,
  input  logic [TILE_AW-1:0] raddr_i,
  output logic [IDX_W-1:0]   rdata_o
);

  logic [IDX_W-1:0] mem_q [NUM_TILES];
  logic [IDX_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tile_map_fetch.sv
// Tile name-table: game-logic write port, clear sweep, and beam-ahead fetch of sprite number/row.
module tile_map_fetch
  import tile_map_fetch_pkg::*;
(
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic [COORD_W-1:0] i_Column,
  input  logic [COORD_W-1:0] i_Row,
  input  logic               i_Wr_Valid,
  output logic               o_Wr_Ready,
  input  logic [TX_W-1:0]    i_Wr_X,
  input  logic [TY_W-1:0]    i_Wr_Y,
  input  logic [IDX_W-1:0]   i_Wr_Data,
  input  logic               i_Clear,
  output logic               o_Busy,
  output logic               o_Wr_Error,
  output logic [IDX_W-1:0]   o_Sprite_Num,
  output logic [SROW_W-1:0]  o_Sprite_Row
);

  localparam int unsigned LOOK_W     = COORD_W + 1;
  // Address issues two cycles before the update edge, so look two columns further than +3.
  localparam int unsigned FETCH_LEAD = 5;
  localparam logic [3:0]  PH_ISSUE   = 4'd11;
  localparam logic [3:0]  PH_UPDATE  = 4'd13;

  map_state_e         state_q, state_d;
  logic [TILE_AW-1:0] clr_addr_q, clr_addr_d;
  logic               err_q, err_d;

  tile_wr_t           wr_req;
  logic               wr_in_range;
  logic               ram_we;
  logic [TILE_AW-1:0] ram_waddr;
  logic [IDX_W-1:0]   ram_wdata;
  logic [IDX_W-1:0]   ram_rdata;

  logic [LOOK_W-1:0]  look_col;
  logic               look_wrap;
  logic [COORD_W-1:0] tgt_col, tgt_row;
  logic               tgt_blank;
  logic [TILE_AW-1:0] tgt_addr;

  logic [TILE_AW-1:0] rd_addr_q;
  logic [SROW_W-1:0]  srow_q;
  logic               blank_q;
  logic               kill_q;
  logic [IDX_W-1:0]   num_q;
  logic [SROW_W-1:0]  row_q;

  assign wr_req      = '{y: i_Wr_Y, x: i_Wr_X, data: i_Wr_Data};
  assign wr_in_range = (wr_req.x < TX_W'(TILES_X)) && (wr_req.y < TY_W'(TILES_Y));

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      err_q      <= err_d;
    end
  end

  // Clear sweep owns the write port while busy; otherwise accepted in-range writes use it.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    err_d      = err_q;
    ram_we     = 1'b0;
    ram_waddr  = '0;
    ram_wdata  = '0;
    unique case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr_q;
        if (clr_addr_q == TILE_AW'(NUM_TILES - 1)) begin
          state_d = IDLE;
        end else begin
          clr_addr_d = clr_addr_q + TILE_AW'(1);
        end
      end
      IDLE: begin
        if (i_Wr_Valid) begin
          if (wr_in_range) begin
            ram_we    = 1'b1;
            ram_waddr = tile_addr(wr_req.y, wr_req.x);
            ram_wdata = wr_req.data;
          end else begin
            err_d = 1'b1;
          end
        end
        if (i_Clear) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
    endcase
  end

  assign look_col  = LOOK_W'(i_Column) + LOOK_W'(FETCH_LEAD);
  assign look_wrap = look_col >= LOOK_W'(H_MAX);
  assign tgt_col   = look_wrap ? COORD_W'(look_col - LOOK_W'(H_MAX)) : COORD_W'(look_col);

  always_comb begin
    tgt_row = i_Row;
    if (look_wrap) begin
      tgt_row = (i_Row == COORD_W'(V_MAX - 1)) ? '0 : i_Row + COORD_W'(1);
    end
  end

  assign tgt_blank = (tgt_col >= COORD_W'(H_ACTIVE)) || (tgt_row >= COORD_W'(V_ACTIVE));
  assign tgt_addr  = tgt_blank ? '0
                               : tile_addr(TY_W'(tgt_row >> TILE_SHIFT), TX_W'(tgt_col >> TILE_SHIFT));

  // Issue (phase 11) -> RAM read (phase 12) -> output register (phase 13).
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      rd_addr_q <= '0;
      srow_q    <= '0;
      blank_q   <= 1'b1;
      kill_q    <= 1'b1;
      num_q     <= '0;
      row_q     <= '0;
    end else begin
      if (i_Column[3:0] == PH_ISSUE) begin
        rd_addr_q <= tgt_addr;
        srow_q    <= tgt_row[3:1];
        blank_q   <= tgt_blank;
      end
      // A read taken mid-sweep may see uncleared data; the cleared map is all zero anyway.
      kill_q <= blank_q || (state_q == CLEAR);
      if (i_Column[3:0] == PH_UPDATE) begin
        row_q <= srow_q;
        num_q <= (kill_q || (state_q == CLEAR)) ? '0 : ram_rdata;
      end
    end
  end

  tile_map_ram u_ram (
    .clk_i   (i_Clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (rd_addr_q),
    .rdata_o (ram_rdata)
  );

  assign o_Busy       = (state_q == CLEAR);
  assign o_Wr_Ready   = (state_q == IDLE);
  assign o_Wr_Error   = err_q;
  assign o_Sprite_Num = num_q;
  assign o_Sprite_Row = row_q;

endmodule

// File: tb/tb_tile_map_fetch.sv
// Bench for tile_map_fetch: frame-level map model checked every cycle plus directed literal checks.
module tb_tile_map_fetch;

  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic [9:0] i_Column;
  logic [9:0] i_Row;
  logic       i_Wr_Valid;
  logic       o_Wr_Ready;
  logic [5:0] i_Wr_X;
  logic [4:0] i_Wr_Y;
  logic [5:0] i_Wr_Data;
  logic       i_Clear;
  logic       o_Busy;
  logic       o_Wr_Error;
  logic [5:0] o_Sprite_Num;
  logic [2:0] o_Sprite_Row;

  tile_map_fetch dut (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_Column     (i_Column),
    .i_Row        (i_Row),
    .i_Wr_Valid   (i_Wr_Valid),
    .o_Wr_Ready   (o_Wr_Ready),
    .i_Wr_X       (i_Wr_X),
    .i_Wr_Y       (i_Wr_Y),
    .i_Wr_Data    (i_Wr_Data),
    .i_Clear      (i_Clear),
    .o_Busy       (o_Busy),
    .o_Wr_Error   (o_Wr_Error),
    .o_Sprite_Num (o_Sprite_Num),
    .o_Sprite_Row (o_Sprite_Row)
  );

  initial forever #5 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Beam generator; a requested jump is taken only outside the phase 11/12 fetch window.
  int jump_col = 0, jump_row = 0, jump_seq = 0, jump_seen = 0;
  initial begin
    i_Column = '0;
    i_Row    = '0;
    forever begin
      @(negedge i_Clk);
      if (jump_seq != jump_seen && i_Column[3:0] != 4'd11 && i_Column[3:0] != 4'd12) begin
        i_Column  = 10'(jump_col);
        i_Row     = 10'(jump_row);
        jump_seen = jump_seq;
      end else if (i_Column == 10'd799) begin
        i_Column = '0;
        i_Row    = (i_Row == 10'd524) ? 10'd0 : i_Row + 10'd1;
      end else begin
        i_Column = i_Column + 10'd1;
      end
    end
  end

  // Behavioural model: map array, clear countdown, and the map as it stood at each read edge.
  logic [5:0] map  [1200];
  logic [5:0] snap [1200];
  bit m_valid = 0;
  int clr_cnt = 0;
  int m_err = 0, m_num = 0, m_row = 0;
  initial forever begin
    int col, row, tc, tr;
    bit busy_now;
    @(posedge i_Clk);
    col = int'(i_Column);
    row = int'(i_Row);
    if (i_Reset) begin
      m_valid = 1;
      clr_cnt = 1200;
      m_err = 0; m_num = 0; m_row = 0;
      for (int i = 0; i < 1200; i++) begin map[i] = '0; snap[i] = '0; end
    end else begin
      busy_now = (clr_cnt > 0);
      if (col % 16 == 12) snap = map;
      if (col % 16 == 13) begin
        tc = col + 3;
        tr = row;
        if (tc >= 800) begin tc -= 800; tr = (tr == 524) ? 0 : tr + 1; end
        m_row = (tr / 2) % 8;
        if (busy_now || tc >= 640 || tr >= 480) m_num = 0;
        else m_num = int'(snap[(tr / 16) * 40 + tc / 16]);
      end
      if (busy_now) clr_cnt--;
      else begin
        if (i_Wr_Valid) begin
          if (i_Wr_X < 6'd40 && i_Wr_Y < 5'd30) map[int'(i_Wr_Y) * 40 + int'(i_Wr_X)] = i_Wr_Data;
          else m_err = 1;
        end
        if (i_Clear) begin
          clr_cnt = 1200;
          for (int i = 0; i < 1200; i++) map[i] = '0;
        end
      end
    end
  end

  initial forever begin
    @(negedge i_Clk);
    if (m_valid) begin
      check("busy", int'(o_Busy), (clr_cnt > 0) ? 1 : 0);
      check("ready", int'(o_Wr_Ready), (clr_cnt > 0) ? 0 : 1);
      check("wr_error", int'(o_Wr_Error), m_err);
      check("sprite_num", int'(o_Sprite_Num), m_num);
      check("sprite_row", int'(o_Sprite_Row), m_row);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic jump(input int c, input int r);
    jump_col = c;
    jump_row = r;
    jump_seq++;
  endtask

  task automatic wait_beam(input int c, input int r, input string name);
    int n = 0;
    do begin
      @(posedge i_Clk); #1;
      n++;
    end while (!(int'(i_Column) == c && int'(i_Row) == r) && n < 2000);
    check({"reach ", name}, (int'(i_Column) == c && int'(i_Row) == r) ? 1 : 0, 1);
  endtask

  task automatic do_write(input int x, input int y, input int d, output int waited);
    i_Wr_X     = 6'(x);
    i_Wr_Y     = 5'(y);
    i_Wr_Data  = 6'(d);
    i_Wr_Valid = 1'b1;
    waited     = 0;
    while (!o_Wr_Ready && waited < 3000) begin
      @(posedge i_Clk); #1;
      waited++;
    end
    check("write ready", int'(o_Wr_Ready), 1);
    @(posedge i_Clk); #1;
    i_Wr_Valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (o_Busy && n < 5000) begin
      i_Clear = (n == 500);
      @(posedge i_Clk); #1;
      n++;
    end
    i_Clear = 1'b0;
  endtask

  initial begin
    int n, w;
    bit held;
    i_Reset = 1'b1; i_Clear = 1'b0; i_Wr_Valid = 1'b0;
    i_Wr_X = '0; i_Wr_Y = '0; i_Wr_Data = '0;
    @(posedge i_Clk); #1;
    i_Reset = 1'b0;
    check("rst busy", int'(o_Busy), 1);
    check("rst ready", int'(o_Wr_Ready), 0);
    check("rst num", int'(o_Sprite_Num), 0);
    check("rst row", int'(o_Sprite_Row), 0);
    check("rst err", int'(o_Wr_Error), 0);

    // Sweep length, with an i_Clear pulse at sweep cycle 500 that must be ignored.
    count_busy(n);
    check("clear length", n, 1200);
    check("ready after clear", int'(o_Wr_Ready), 1);
    repeat (200) @(posedge i_Clk);
    #1;

    do_write(5, 2, 'h2A, w);
    do_write(0, 0, 'h11, w);
    do_write(0, 1, 'h05, w);
    do_write(39, 2, 'h07, w);
    check("no error", int'(o_Wr_Error), 0);

    jump(70, 32);
    wait_beam(77, 32, "77/32");
    check("fetch 5,2 num", int'(o_Sprite_Num), 'h2A);
    check("fetch 5,2 row", int'(o_Sprite_Row), 0);
    held = 1;
    repeat (15) begin
      @(posedge i_Clk); #1;
      if (o_Sprite_Num != 6'h2A) held = 0;
    end
    check("hold 16", int'(held), 1);
    @(posedge i_Clk); #1;
    check("next tile 6,2", int'(o_Sprite_Num), 0);

    jump(70, 37);
    wait_beam(77, 37, "77/37");
    check("row 37 bits", int'(o_Sprite_Row), 2);
    check("row 37 num", int'(o_Sprite_Num), 'h2A);

    jump(790, 524);
    wait_beam(797, 524, "frame wrap");
    check("frame wrap num", int'(o_Sprite_Num), 'h11);
    check("frame wrap row", int'(o_Sprite_Row), 0);
    jump(784, 15);
    wait_beam(797, 15, "line wrap");
    check("line wrap num", int'(o_Sprite_Num), 'h05);
    check("line wrap row", int'(o_Sprite_Row), 0);

    // X=40,Y=0 would alias tile (0,1) if not dropped.
    do_write(40, 0, 'h3F, w);
    check("oor error", int'(o_Wr_Error), 1);
    jump(784, 15);
    wait_beam(797, 15, "oor map");
    check("oor map unchanged", int'(o_Sprite_Num), 'h05);
    jump(614, 32);
    wait_beam(621, 32, "tile 39");
    check("tile 39 num", int'(o_Sprite_Num), 'h07);
    wait_beam(637, 32, "h blank");
    check("h blank num", int'(o_Sprite_Num), 0);

    // Write held across a requested clear lands on the first IDLE edge.
    i_Clear = 1'b1;
    @(posedge i_Clk); #1;
    i_Clear = 1'b0;
    check("clear busy", int'(o_Busy), 1);
    do_write(3, 3, 'h15, w);
    check("backpressure wait", w, 1200);
    check("error sticky", int'(o_Wr_Error), 1);
    jump(70, 32);
    wait_beam(77, 32, "cleared 5,2");
    check("cleared 5,2", int'(o_Sprite_Num), 0);
    jump(38, 48);
    wait_beam(45, 48, "tile 3,3");
    check("tile 3,3", int'(o_Sprite_Num), 'h15);

    // Collision: write lands on the same edge the RAM reads tile (3,3).
    jump(38, 48);
    wait_beam(43, 48, "collide");
    do_write(3, 3, 'h2C, w);
    @(posedge i_Clk); #1;
    check("collide old", int'(o_Sprite_Num), 'h15);
    jump(38, 48);
    wait_beam(45, 48, "collide next");
    check("collide new", int'(o_Sprite_Num), 'h2C);

    i_Reset = 1'b1;
    @(posedge i_Clk); #1;
    i_Reset = 1'b0;
    check("rst2 err", int'(o_Wr_Error), 0);
    check("rst2 busy", int'(o_Busy), 1);
    check("rst2 num", int'(o_Sprite_Num), 0);
    count_busy(n);
    check("rst2 clear length", n, 1200);
    repeat (40) @(posedge i_Clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
